iob_native_arbiter: RTL and testbench
=====================================

Name: iob_native_arbiter

Overview:
- Parametrised N-to-1 arbiter for the iob native bus (valid/addr/wdata/wstrb/rdata/ready).
- Successor to the fixed 2-master shared-memory path in the simulation top: master count, address and data widths, arbitration mode and a slave-response watchdog are all configurable.
- Sits between N masters (CPU I/D ports, accelerators, DMA) and a single memory or peripheral slave.
- Serialises requests, routes the response to the granted master, and flags a slave that never answers.

Parameters:
- N_MASTERS, 2: number of master ports, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width, multiple of 8.
- ARB_MODE, 0: 0 = round robin; 1 = fixed priority, lowest index wins.
- TIMEOUT, 0: slave response limit in cycles; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: rdata returned on timeout, truncated or zero-extended to DATA_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_valid  in  N_MASTERS  per-master request
- m_addr  in  N_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  packed write data
- m_wstrb  in  N_MASTERS*DATA_W/8  packed strobes; all-zero means read
- m_rdata  out  N_MASTERS*DATA_W  packed read data, valid only with the matching m_ready bit
- m_ready  out  N_MASTERS  one-cycle completion pulse per master
- s_valid  out  1  request to slave
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave strobe
- s_rdata  in  DATA_W  slave read data
- s_ready  in  1  slave completion pulse
- grant  out  $clog2(N_MASTERS) (min 1)  index of the current or last granted master
- busy  out  1  high in BUSY state
- timeout_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- Protocol:
  - A master holds m_valid and its addr/wdata/wstrb stable until it sees its m_ready pulse.
  - It drops or renews m_valid in the cycle after the pulse.
  - The slave pulses s_ready for exactly one cycle per request.
- FSM states are IDLE and BUSY.
- IDLE:
  - If any m_valid is set, select a winner, register its index into grant and register its addr/wdata/wstrb onto the s_* outputs.
  - Set s_valid=1 and go to BUSY on the next edge.
  - Arbitration latency is one cycle: the request is visible on s_valid in the cycle after m_valid is first sampled in IDLE.
- BUSY:
  - s_valid stays high and s_* stay stable.
  - m_valid of other masters is ignored.
  - When s_ready=1: m_ready[grant]=1 and m_rdata[grant]=s_rdata combinationally in that cycle. s_valid drops on the next edge; the next state is IDLE.
  - The minimum issue period per request is therefore 2 cycles plus slave latency.
- Round robin (ARB_MODE=0):
  - Priority pointer ptr resets to 0.
  - The winner is the first asserted m_valid scanning ptr, ptr+1, … with wrap modulo N_MASTERS.
  - On completion, ptr <= grant+1, wrapping N_MASTERS-1 to 0.
  - One master holding m_valid continuously cannot starve others: each requester waits at most N_MASTERS-1 transactions.
- Fixed priority (ARB_MODE=1): the lowest asserted index wins; ptr is unused.
- Watchdog (TIMEOUT>0):
  - A counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When it reaches TIMEOUT, the block completes the transaction itself: m_ready[grant]=1, m_rdata[grant]=ERR_DATA, timeout_err<=1, s_valid drops, return to IDLE.
  - The counter width is sized for TIMEOUT.
  - If s_ready arrives in the same cycle the count reaches TIMEOUT, s_ready wins and no error is flagged.
  - An s_ready arriving later in IDLE is ignored.
- Simultaneous requests in the same cycle are resolved purely by mode and ptr; there is no combinational path from m_valid to s_valid.
- All m_ready bits other than m_ready[grant] are 0 at all times; m_rdata of non-granted masters is 0.
- Reset, including mid-transaction:
  - Next edge: state=IDLE, s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, m_ready=0, m_rdata=0, grant=0, ptr=0, busy=0, timeout_err=0, counter=0.
  - An in-flight transaction is abandoned with no m_ready pulse.
  - An s_ready arriving after reset is ignored.
- N_MASTERS=1 degenerates to a registered pass-through with the watchdog still active.

Test Plan:
- Single read: master 1 requests addr 0x100, wstrb 0; slave answers 0x12345678 three cycles after s_valid -> s_valid one cycle after request with s_addr=0x100; m_ready[1] pulses one cycle with m_rdata[1]=0x12345678; grant=1.
- Round robin fairness: N=4, all m_valid held high, slave 1-cycle latency -> grant sequence 0,1,2,3,0,… and no master served twice before the others.
- Fixed priority: ARB_MODE=1, masters 0 and 2 always requesting -> master 0 served every transaction and master 2 never granted; drop master 0 -> master 2 granted next.
- Write routing: master 3 writes 0xCAFEF00D to 0x40, wstrb 4'b0011 -> s_wdata/s_wstrb match exactly; only m_ready[3] pulses.
- Watchdog: TIMEOUT=8, slave never answers -> m_ready pulses with ERR_DATA 8 cycles after entering BUSY and timeout_err stays 1; a variant with s_ready on cycle 8 -> normal data and timeout_err=0.
- Reset mid-operation: assert rst while BUSY -> next cycle s_valid=0, busy=0, no m_ready pulse; a late s_ready is ignored; a new request then completes normally from grant 0.

Source files
------------

// File: rtl/iob_native_arbiter.sv
// rtl/iob_native_arbiter.sv - N-to-1 iob native bus arbiter with round-robin/fixed priority and slave watchdog
module iob_native_arbiter #(
    parameter int          N_MASTERS = 2,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          ARB_MODE  = 0,
    parameter int          TIMEOUT   = 0,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF,
    localparam int         GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [GW-1:0]                 grant,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int                CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_W-1:0] ERR_D = DATA_W'(ERR_DATA);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, ptr_q, base, win;
    logic [ADDR_W-1:0]       s_addr_q, nxt_addr;
    logic [DATA_W-1:0]       s_wdata_q, nxt_wdata;
    logic [DATA_W/8-1:0]     s_wstrb_q, nxt_wstrb;
    logic [CW-1:0]           cnt_q;
    logic                    terr_q;
    logic                    any_req, to_hit, done;
    logic [2*N_MASTERS-1:0]  rot_req;
    int                      sel;

    // Rotate the request vector so that index 0 is the highest-priority master.
    always_comb begin
        base    = (ARB_MODE == 0) ? ptr_q : '0;
        rot_req = {m_valid, m_valid} >> base;
        any_req = 1'b0;
        sel     = 0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                any_req = 1'b1;
                sel     = (int'(base) + i) % N_MASTERS;
            end
        end
        win       = GW'(sel);
        nxt_addr  = '0;
        nxt_wdata = '0;
        nxt_wstrb = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (j == sel) begin
                nxt_addr  = m_addr[j*ADDR_W +: ADDR_W];
                nxt_wdata = m_wdata[j*DATA_W +: DATA_W];
                nxt_wstrb = m_wstrb[j*(DATA_W/8) +: DATA_W/8];
            end
        end
    end

    // A slave answer in the limit cycle takes precedence over the watchdog.
    assign to_hit = (TIMEOUT > 0) && (state_q == BUSY) && !s_ready
                    && (cnt_q == CW'(TIMEOUT - 1));
    assign done   = (state_q == BUSY) && !rst && (s_ready || to_hit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (s_ready || to_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ready = '0;
        m_rdata = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (done && (grant_q == GW'(j))) begin
                m_ready[j]                 = 1'b1;
                m_rdata[j*DATA_W +: DATA_W] = s_ready ? s_rdata : ERR_D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && any_req) begin
                grant_q   <= win;
                s_addr_q  <= nxt_addr;
                s_wdata_q <= nxt_wdata;
                s_wstrb_q <= nxt_wstrb;
                cnt_q     <= '0;
            end
            if (state_q == BUSY) begin
                if (s_ready || to_hit) begin
                    if (to_hit) terr_q <= 1'b1;
                    if (ARB_MODE == 0)
                        ptr_q <= (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                end else if (TIMEOUT > 0) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign s_valid     = (state_q == BUSY);
    assign busy        = (state_q == BUSY);
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign grant       = grant_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_iob_native_arbiter.sv
// tb/tb_iob_native_arbiter.sv - randomized check of two arbiter instances (round robin + watchdog, fixed priority)
module tb_iob_native_arbiter;

    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [3:0]   m_valid [2];
    logic [127:0] m_addr [2], m_wdata [2], m_rdata [2];
    logic [15:0]  m_wstrb [2];
    logic [3:0]   m_ready [2];
    logic         s_valid [2], s_ready [2], busy [2], timeout_err [2];
    logic [31:0]  s_addr [2], s_wdata [2], s_rdata [2];
    logic [3:0]   s_wstrb [2];
    logic [1:0]   grant [2];

    for (genvar u = 0; u < 2; u++) begin : g_dut
        iob_native_arbiter #(
            .N_MASTERS(4), .ADDR_W(32), .DATA_W(32),
            .ARB_MODE(u), .TIMEOUT((u == 0) ? 8 : 0)
        ) dut (
            .clk(clk), .rst(rst),
            .m_valid(m_valid[u]), .m_addr(m_addr[u]), .m_wdata(m_wdata[u]),
            .m_wstrb(m_wstrb[u]), .m_rdata(m_rdata[u]), .m_ready(m_ready[u]),
            .s_valid(s_valid[u]), .s_addr(s_addr[u]), .s_wdata(s_wdata[u]),
            .s_wstrb(s_wstrb[u]), .s_rdata(s_rdata[u]), .s_ready(s_ready[u]),
            .grant(grant[u]), .busy(busy[u]), .timeout_err(timeout_err[u])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc_now = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc_now, obs, exp);
        end
    endtask

    // Reference model: transaction-level view of each arbiter
    bit          mbusy [2], merr [2];
    int          mgnt [2], mptr [2], mwait [2];
    logic [31:0] eaddr [2], ewdata [2];
    logic [3:0]  ewstrb [2];
    // Masters and slaves of the environment
    bit          pend [2][4], got [2][4];
    logic [31:0] raddr [2][4], rwdata [2][4];
    logic [3:0]  rwstrb [2][4];
    int          waitn [4];
    bit          sact [2], sfired [2];
    int          scnt [2], slat [2];
    int          n_to = 0, n_late7 = 0, n_fp2_sat = 0, n_fp2_after = 0;

    function automatic int to_of(int u);
        return (u == 0) ? 8 : 0;
    endfunction

    function automatic bit may_req(int u, int i, int cyc);
        if (cyc >= 1500 && cyc < 2100) return (u == 0) || (i == 0) || (i == 2);
        if (cyc >= 2100 && cyc < 2300) return (u == 0) || (i == 2);
        return 1'b1;
    endfunction

    function automatic int pick(int u);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (u == 1) ? k : (mptr[u] + k) % 4;
            if (pend[u][idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int pick_lat(int u, int cyc);
        int r;
        if (cyc >= 1500 && cyc < 2300) return 0;
        r = $urandom_range(0, 15);
        if (u == 0 && r == 0) return 255;
        if (r == 1) return 7;
        if (r == 2) return 6;
        return $urandom_range(0, 3);
    endfunction

    task automatic model_reset(int u);
        mbusy[u] = 0; merr[u] = 0; mgnt[u] = 0; mptr[u] = 0; mwait[u] = 0;
        eaddr[u] = '0; ewdata[u] = '0; ewstrb[u] = '0;
        if (u == 0) for (int i = 0; i < 4; i++) waitn[i] = 0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = '0; m_addr[u] = '0; m_wdata[u] = '0; m_wstrb[u] = '0;
            s_ready[u] = 1'b0; s_rdata[u] = '0; sact[u] = 0; sfired[u] = 0;
            scnt[u] = 0; slat[u] = 0;
            for (int i = 0; i < 4; i++) begin pend[u][i] = 0; got[u][i] = 0; end
            model_reset(u);
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            bit rst_now;
            @(negedge clk);
            cyc_now = cyc;
            rst_now = (cyc < 4) || (cyc >= 2300 && $urandom_range(0, 99) == 0);
            rst = rst_now;
            for (int u = 0; u < 2; u++) begin
                int prob;
                prob = (cyc >= 1500 && cyc < 2300) ? 100 : 40;
                for (int i = 0; i < 4; i++) begin
                    if (got[u][i]) begin pend[u][i] = 0; got[u][i] = 0; end
                    if (!pend[u][i] && may_req(u, i, cyc) && $urandom_range(0, 99) < prob) begin
                        pend[u][i]   = 1;
                        raddr[u][i]  = $urandom;
                        rwdata[u][i] = $urandom;
                        rwstrb[u][i] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                        if (u == 0) waitn[i] = 0;
                    end
                    m_valid[u][i]         = pend[u][i];
                    m_addr[u][i*32 +: 32]  = raddr[u][i];
                    m_wdata[u][i*32 +: 32] = rwdata[u][i];
                    m_wstrb[u][i*4 +: 4]   = rwstrb[u][i];
                end
                // Slave: one s_ready pulse per request, stray pulses while idle
                if (s_valid[u]) begin
                    if (!sact[u]) begin
                        sact[u] = 1; sfired[u] = 0; scnt[u] = 0; slat[u] = pick_lat(u, cyc);
                    end
                    s_ready[u] = !sfired[u] && (scnt[u] == slat[u]);
                    if (s_ready[u]) sfired[u] = 1;
                    scnt[u]++;
                end else begin
                    sact[u]    = 0;
                    s_ready[u] = ($urandom_range(0, 7) == 0);
                end
                s_rdata[u] = $urandom;
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                bit           done, tmo;
                logic [127:0] erd, ord;
                logic [3:0]   erdy;
                done = mbusy[u] && !rst_now
                       && (s_ready[u] || (to_of(u) > 0 && mwait[u] == to_of(u) - 1));
                tmo  = done && !s_ready[u];
                chk($sformatf("busy%0d", u), busy[u], mbusy[u]);
                chk($sformatf("s_valid%0d", u), s_valid[u], mbusy[u]);
                chk($sformatf("grant%0d", u), grant[u], mgnt[u]);
                chk($sformatf("timeout_err%0d", u), timeout_err[u], merr[u]);
                chk($sformatf("s_req%0d", u), {s_addr[u], s_wdata[u], s_wstrb[u]},
                    {eaddr[u], ewdata[u], ewstrb[u]});
                erdy = done ? (4'b1 << mgnt[u]) : 4'b0;
                chk($sformatf("m_ready%0d", u), m_ready[u], erdy);
                erd = '0;
                ord = m_rdata[u];
                if (done) erd[mgnt[u]*32 +: 32] = tmo ? 32'hDEADBEEF : s_rdata[u];
                else      ord[mgnt[u]*32 +: 32] = '0;
                chk($sformatf("m_rdata%0d", u), ord, erd);
                if (done) begin
                    got[u][mgnt[u]] = 1;
                    if (u == 0) begin
                        chk("rr_wait_bound", waitn[mgnt[u]] <= 3, 1'b1);
                        for (int i = 0; i < 4; i++)
                            if (i != mgnt[u] && pend[0][i]) waitn[i]++;
                        waitn[mgnt[u]] = 0;
                        if (tmo) n_to++;
                        if (!tmo && mwait[u] == 7) n_late7++;
                    end else if (mgnt[u] == 2) begin
                        if (cyc >= 1520 && cyc < 2100) n_fp2_sat++;
                        if (cyc >= 2100 && cyc < 2300) n_fp2_after++;
                    end
                end
                // Advance the model to the state after the coming edge
                if (rst_now) begin
                    model_reset(u);
                end else if (!mbusy[u]) begin
                    int w;
                    w = pick(u);
                    if (w >= 0) begin
                        mbusy[u] = 1; mgnt[u] = w; mwait[u] = 0;
                        eaddr[u] = raddr[u][w]; ewdata[u] = rwdata[u][w]; ewstrb[u] = rwstrb[u][w];
                    end
                end else if (done) begin
                    mbusy[u] = 0;
                    if (tmo) merr[u] = 1;
                    if (u == 0) mptr[u] = (mgnt[u] + 1) % 4;
                end else begin
                    mwait[u]++;
                end
            end
        end
        chk("watchdog_fired", n_to > 0, 1'b1);
        chk("late_ready_wins", n_late7 > 0, 1'b1);
        chk("fp_master2_starved", n_fp2_sat, 0);
        chk("fp_master2_after_drop", n_fp2_after > 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
